hazard_scoreboard: RTL

Parametrised data-hazard unit for the pipelined CPU. It replaces the purely combinational per-stage address comparison with an internal shadow pipeline. The shadow pipeline records the destination register and result class of every instruction issued from ID, and advances with the datapath. From it the unit generates per-operand forwarding selects, a load-use stall whose length depends on when load data becomes available, a freeze on data-memory wait, and a saturating stall-cycle counter. It sits beside the ID stage and drives the operand muxes and the IF/ID/PC write enables.

---
 rtl/hazard_scoreboard.sv | 94 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: a shadow pipeline of destination registers drives operand
// forwarding selects, load-use stalls, memory-wait freeze and a stall counter.
module hazard_scoreboard #(
  parameter  int REG_AW             = 2,
  parameter  int DEPTH              = 3,
  parameter  int LOAD_READY_STAGE   = 2,
  parameter  bit ZERO_REG_HARDWIRED = 1'b0,
  localparam int FW                 = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              stall,
  output logic [FW-1:0]     fwd_rs,
  output logic [FW-1:0]     fwd_rt,
  output logic [15:0]       stall_count
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } shadow_t;

  typedef shadow_t [DEPTH:1] shadow_vec_t;

  typedef struct packed {
    logic          hz;
    logic [FW-1:0] fwd;
  } lookup_t;

  shadow_vec_t sh;
  lookup_t     lk_rs;
  lookup_t     lk_rt;
  logic        load_use;

  // The youngest matching stage wins; a load that is too young stalls instead.
  function automatic lookup_t lookup(shadow_vec_t s, logic [REG_AW-1:0] r, logic active);
    lookup_t res;
    logic    found;
    // NOTE: every result field gets a default before any branch, so the
    // combinational logic built from this never has to remember a value.
    res   = '0;
    found = 1'b0;
    if (active && !(ZERO_REG_HARDWIRED && r == '0)) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found && s[k].v && s[k].wr && s[k].rd == r) begin
          found = 1'b1;
          if (s[k].ld && k < LOAD_READY_STAGE) res.hz = 1'b1;
          else                                 res.fwd = FW'(k);
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    lk_rs    = lookup(sh, id_rs, id_valid && id_use_rs);
    lk_rt    = lookup(sh, id_rt, id_valid && id_use_rt);
    load_use = lk_rs.hz | lk_rt.hz;
    stall    = load_use | !mem_ready;
    fwd_rs   = lk_rs.fwd;
    fwd_rt   = lk_rt.fwd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shadow pipeline is control state, not storage; clearing it
      // is what guarantees no stale hazard or forward right after reset.
      sh          <= '0;
      stall_count <= '0;
    end else if (mem_ready) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's
      // old value, so the shift works regardless of statement order.
      sh[1] <= '{v:  id_valid && !load_use && !flush,
                 wr: id_reg_write,
                 rd: id_rd,
                 ld: id_is_load};
      for (int k = 2; k <= DEPTH; k++) sh[k] <= sh[k-1];
      if (load_use && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule
